// File: rtl/modinv_binary_pkg.sv
// modinv_binary: shared types and modular helpers for the inverse/gcd datapath.
// Helpers work on a wide container; callers zero-extend in and truncate out.
package modinv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REDUCE,
    RUN,
    DONE
  } state_t;

  localparam logic MODE_INV = 1'b0;
  localparam logic MODE_GCD = 1'b1;

  localparam int MAX_W = 4096;

  typedef logic [MAX_W+1:0] wide_t;

  // (x + (x odd ? m : 0)) / 2, for x in [0, m)
  function automatic wide_t mod_half(
    input wide_t x,
    input wide_t m
  );
    wide_t s;
    s = x[0] ? x + m : x;
    return s >> 1;
  endfunction

  // (x - y) mod m, for x, y in [0, m)
  function automatic wide_t mod_sub(
    input wide_t x,
    input wide_t y,
    input wide_t m
  );
    return (x >= y) ? x - y : x + m - y;
  endfunction

endpackage

// File: rtl/modinv_binary_if.sv
// modinv_binary: request/result bundle between requester and the inverter.
// MODINV_CYCLE_COUNT_EN adds the cycles_out result field.
interface modinv_binary_if #(
  parameter int WIDTH = 512,
  parameter int CNT_W = 16
);

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] base;
  logic             mode_in;
  logic             valid_in;
  logic [WIDTH-1:0] b_out;
  logic             valid_out;
  logic             busy_out;
  logic             error_out;
`ifdef MODINV_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycles_out;
`endif

  if ((2 ** CNT_W) <= 5 * WIDTH + 4) begin : g_bad_cnt
    $error("CNT_W too narrow for WIDTH");
  end

`ifdef MODINV_CYCLE_COUNT_EN
  modport master (
    output a_in, base, mode_in, valid_in,
    input  b_out, valid_out, busy_out,
    input  error_out, cycles_out
  );
  modport slave (
    input  a_in, base, mode_in, valid_in,
    output b_out, valid_out, busy_out,
    output error_out, cycles_out
  );
`else
  modport master (
    output a_in, base, mode_in, valid_in,
    input  b_out, valid_out, busy_out,
    input  error_out
  );
  modport slave (
    input  a_in, base, mode_in, valid_in,
    output b_out, valid_out, busy_out,
    output error_out
  );
`endif

endinterface

// File: rtl/modinv_binary_mod_reduce.sv
// mod_reduce: restoring shift-subtract remainder a mod m.
// One quotient bit per cycle; done_o marks the last of exactly WIDTH cycles.
module mod_reduce #(
  parameter int WIDTH = 512
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] m_i,
  output logic             done_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q, m_q, r_q, r_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   sh;

  // Shift the next dividend bit in and subtract m when it fits.
  always_comb begin
    sh = {r_q, a_q[WIDTH-1]};
    r_d = sh[WIDTH-1:0];
    if (sh >= {1'b0, m_q}) begin
      r_d = WIDTH'(sh - {1'b0, m_q});
    end
  end

  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign rem_o  = r_d;

  // Operand capture on start, then one step per cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_q    <= '0;
      m_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      m_q    <= m_i;
      r_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      a_q   <= a_q << 1;
      r_q   <= r_d;
      cnt_q <= cnt_q + CW'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/modinv_binary.sv
// modinv_binary: a^-1 mod m (or gcd) by binary extended Euclid.
// MODINV_CYCLE_COUNT_EN adds a saturating busy-cycle counter on cycles_out.
module modinv_binary
  import modinv_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int CNT_W = 16
) (
  input logic           clk_in,
  input logic           rst_n_in,
  modinv_binary_if.slave io
);

  localparam int XW = WIDTH + 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  if (WIDTH < 8 || WIDTH > MAX_W) begin : g_bad_w
    $error("WIDTH out of range");
  end
  if ((2 ** CNT_W) <= 5 * WIDTH + 4) begin : g_bad_cnt
    $error("CNT_W too narrow for WIDTH");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] u_q, u_d, v_q, v_d, m_q, m_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [XW-1:0]    x1_q, x1_d, x2_q, x2_d;
  logic             mode_q, mode_d, err_q, err_d;
  logic             red_start, red_done;
  logic [WIDTH-1:0] red_rem;

  mod_reduce #(.WIDTH(WIDTH)) u_red (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .start_i  (red_start),
    .a_i      (u_q),
    .m_i      (m_q),
    .done_o   (red_done),
    .rem_o    (red_rem)
  );

  // Sequencing plus one Euclid step per RUN cycle.
  always_comb begin
    state_d   = state_q;
    u_d       = u_q;
    v_d       = v_q;
    m_d       = m_q;
    mode_d    = mode_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    b_d       = b_q;
    err_d     = err_q;
    red_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.valid_in) begin
          u_d     = io.a_in;
          v_d     = io.base;
          m_d     = io.base;
          mode_d  = io.mode_in;
          state_d = CHECK;
        end
      end
      CHECK: begin
        x1_d = XW'(1);
        x2_d = '0;
        if (!m_q[0] || m_q < WIDTH'(3)) begin
          b_d     = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (u_q >= m_q) begin
          red_start = 1'b1;
          state_d   = REDUCE;
        end else begin
          state_d = RUN;
        end
      end
      REDUCE: begin
        if (red_done) begin
          u_d     = red_rem;
          state_d = RUN;
        end
      end
      RUN: begin
        if (u_q == ONE) begin
          b_d     = (mode_q == MODE_GCD) ? ONE : x1_q[WIDTH-1:0];
          err_d   = 1'b0;
          state_d = DONE;
        end else if (v_q == ONE) begin
          b_d     = (mode_q == MODE_GCD) ? ONE : x2_q[WIDTH-1:0];
          err_d   = 1'b0;
          state_d = DONE;
        end else if (u_q == '0) begin
          b_d     = (mode_q == MODE_GCD) ? v_q : '0;
          err_d   = (mode_q == MODE_INV);
          state_d = DONE;
        end else if (v_q == '0) begin
          b_d     = (mode_q == MODE_GCD) ? u_q : '0;
          err_d   = (mode_q == MODE_INV);
          state_d = DONE;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = XW'(mod_half(wide_t'(x1_q), wide_t'(m_q)));
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = XW'(mod_half(wide_t'(x2_q), wide_t'(m_q)));
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = XW'(mod_sub(wide_t'(x1_q), wide_t'(x2_q),
                             wide_t'(m_q)));
        end else begin
          v_d  = v_q - u_q;
          x2_d = XW'(mod_sub(wide_t'(x2_q), wide_t'(x1_q),
                             wide_t'(m_q)));
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      m_q     <= '0;
      mode_q  <= 1'b0;
      x1_q    <= '0;
      x2_q    <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      m_q     <= m_d;
      mode_q  <= mode_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      b_q     <= b_d;
      err_q   <= err_d;
    end
  end

  assign io.b_out     = b_q;
  assign io.error_out = err_q;
  assign io.valid_out = (state_q == DONE);
  assign io.busy_out  = (state_q != IDLE);

`ifdef MODINV_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d, cyc_q, cyc_d;

  // Count busy cycles; snapshot the count as DONE is entered.
  always_comb begin
    cnt_d = cnt_q;
    cyc_d = cyc_q;
    if (state_q == IDLE) begin
      if (io.valid_in) begin
        cnt_d = '0;
      end
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (state_d == DONE && state_q != DONE) begin
      cyc_d = cnt_d;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
      cyc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
    end
  end

  assign io.cycles_out = cyc_q;
`endif

endmodule

// File: tb/tb_modinv_binary.sv
// tb_modinv_binary: directed vectors for modinv_binary at WIDTH=16.
// Cycle counts are checked too when MODINV_CYCLE_COUNT_EN is defined.
module tb_modinv_binary;

  localparam int W    = 16;
  localparam int C    = 16;
  localparam int LIM  = 200;
  localparam int LMAX = 2 + 5 * W;
  localparam int NV   = 24;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] m;
    logic         mode;
    logic [W-1:0] b;
    logic         err;
    int           lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  vec_t vt[NV];

  always #5 clk = ~clk;

  modinv_binary_if #(.WIDTH(W), .CNT_W(C)) io ();

  modinv_binary #(.WIDTH(W), .CNT_W(C)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .io       (io)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while (io.busy_out && g < LIM) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] m,
                        input logic md, output int lat);
    wait_idle();
    io.a_in     = a;
    io.base     = m;
    io.mode_in  = md;
    io.valid_in = 1'b1;
    @(posedge clk);
    #1;
    io.valid_in = 1'b0;
    lat = 1;
    while (!io.valid_out && lat < LIM) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!io.valid_out) begin
      n_chk++;
      n_err++;
      $display("FAIL timeout: got no valid_out, want one");
      lat = -1;
    end
  endtask

  initial begin
    int lat, k, np;
    vt[0]  = '{16'd3,     16'd11,    1'b0, 16'd4,     1'b0, 7};
    vt[1]  = '{16'd25,    16'd7,     1'b0, 16'd2,     1'b0, 21};
    vt[2]  = '{16'd6,     16'd9,     1'b0, 16'd0,     1'b1, 0};
    vt[3]  = '{16'd6,     16'd9,     1'b1, 16'd3,     1'b0, 0};
    vt[4]  = '{16'd10,    16'd10,    1'b0, 16'd0,     1'b1, 2};
    vt[5]  = '{16'd5,     16'd1,     1'b0, 16'd0,     1'b1, 2};
    vt[6]  = '{16'd10,    16'd17,    1'b0, 16'd12,    1'b0, 0};
    vt[7]  = '{16'd0,     16'd13,    1'b0, 16'd0,     1'b1, 3};
    vt[8]  = '{16'd0,     16'd13,    1'b1, 16'd13,    1'b0, 3};
    vt[9]  = '{16'd26,    16'd13,    1'b1, 16'd13,    1'b0, 19};
    vt[10] = '{16'd26,    16'd13,    1'b0, 16'd0,     1'b1, 19};
    vt[11] = '{16'd2,     16'd3,     1'b0, 16'd2,     1'b0, 4};
    vt[12] = '{16'd1,     16'd65535, 1'b0, 16'd1,     1'b0, 3};
    vt[13] = '{16'd65534, 16'd65535, 1'b0, 16'd65534, 1'b0, 0};
    vt[14] = '{16'd65535, 16'd65533, 1'b0, 16'd32767, 1'b0, 0};
    vt[15] = '{16'd21,    16'd15,    1'b1, 16'd3,     1'b0, 0};
    vt[16] = '{16'd7,     16'd15,    1'b0, 16'd13,    1'b0, 0};
    vt[17] = '{16'd100,   16'd101,   1'b0, 16'd100,   1'b0, 0};
    vt[18] = '{16'd35,    16'd77,    1'b1, 16'd7,     1'b0, 0};
    vt[19] = '{16'd77,    16'd35,    1'b1, 16'd7,     1'b0, 0};
    vt[20] = '{16'd4,     16'd9,     1'b0, 16'd7,     1'b0, 0};
    vt[21] = '{16'd10,    16'd0,     1'b1, 16'd0,     1'b1, 2};
    vt[22] = '{16'd3,     16'd3,     1'b1, 16'd3,     1'b0, 19};
    vt[23] = '{16'd9,     16'd8,     1'b1, 16'd0,     1'b1, 2};

    io.a_in     = '0;
    io.base     = '0;
    io.mode_in  = 1'b0;
    io.valid_in = 1'b0;

    #12;
    chk("rst b_out", 32'(io.b_out), 0);
    chk("rst valid", 32'(io.valid_out), 0);
    chk("rst busy", 32'(io.busy_out), 0);
    chk("rst err", 32'(io.error_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].a, vt[i].m, vt[i].mode, lat);
      if (lat > 0) begin
        chk($sformatf("v%0d b_out", i), 32'(io.b_out), 32'(vt[i].b));
        chk($sformatf("v%0d err", i), 32'(io.error_out),
            32'(vt[i].err));
        chk($sformatf("v%0d bound", i), 32'(lat <= LMAX), 1);
        if (vt[i].lat != 0) begin
          chk($sformatf("v%0d latency", i), lat, vt[i].lat);
`ifdef MODINV_CYCLE_COUNT_EN
          chk($sformatf("v%0d cycles", i), 32'(io.cycles_out),
              vt[i].lat - 1);
`endif
        end
      end
    end

    run_op(16'd3, 16'd11, 1'b0, lat);
    repeat (5) @(negedge clk);
    chk("hold b_out", 32'(io.b_out), 4);
    chk("hold valid", 32'(io.valid_out), 0);

    wait_idle();
    io.a_in     = 16'd3;
    io.base     = 16'd11;
    io.mode_in  = 1'b0;
    io.valid_in = 1'b1;
    k  = 0;
    np = 0;
    while (np < 3 && k < LIM) begin
      @(negedge clk);
      k++;
      if (io.valid_out) begin
        chk($sformatf("held pulse%0d at", np), k, 8 * np + 7);
        chk($sformatf("held pulse%0d b", np), 32'(io.b_out), 4);
        np++;
      end
    end
    io.valid_in = 1'b0;
    chk("held pulses", np, 3);
    np = 0;
    repeat (20) begin
      @(negedge clk);
      if (io.valid_out) np++;
    end
    chk("extra pulses", np, 0);
    chk("held idle busy", 32'(io.busy_out), 0);

    wait_idle();
    io.a_in     = 16'd65534;
    io.base     = 16'd65535;
    io.mode_in  = 1'b0;
    io.valid_in = 1'b1;
    @(posedge clk);
    #1;
    io.valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("mid-run busy", 32'(io.busy_out), 1);
    rst_n = 1'b0;
    #1;
    chk("abort b_out", 32'(io.b_out), 0);
    chk("abort valid", 32'(io.valid_out), 0);
    chk("abort busy", 32'(io.busy_out), 0);
    chk("abort err", 32'(io.error_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    np = 0;
    repeat (30) begin
      @(negedge clk);
      if (io.valid_out) np++;
    end
    chk("abort pulses", np, 0);
    run_op(16'd10, 16'd17, 1'b0, lat);
    if (lat > 0) begin
      chk("post-abort b_out", 32'(io.b_out), 12);
      chk("post-abort err", 32'(io.error_out), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
